// File: rtl/knn_pkg.sv
// Shared types and constants for the partialKnn search-point datapath.
//   sp_word_t      : one search-point word (SP_DATA_W bits)
//   sp_addr_t      : local search-point buffer address (SP_ADDR_W bits)
//   reader_state_t : stream reader FSM states (IDLE / ISSUE / DRAIN)
package knn_pkg;

  localparam int SP_DATA_W = 256;
  localparam int SP_ADDR_W = 11;

  typedef logic [SP_DATA_W-1:0] sp_word_t;
  typedef logic [SP_ADDR_W-1:0] sp_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/knn_sp_skid_fifo.sv
// Small synchronous FIFO that absorbs buffer read latency for the stream reader.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (empties FIFO)
//   push, push_data     : write one word (caller guarantees not full)
//   pop                 : drop the head word (caller guarantees not empty)
//   head_data           : current head word (valid while !empty)
//   count, empty        : occupancy and empty flag
// The head is read combinationally so the consumer sees it in the same cycle
// it becomes valid; with only a handful of entries this maps to LUT RAM.
module knn_sp_skid_fifo #(
  parameter int DataWidth = 256,
  parameter int Depth     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DataWidth-1:0]         push_data,
  input  logic                         pop,
  output logic [DataWidth-1:0]         head_data,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem_reg [Depth];
  logic [PtrW-1:0]      wr_ptr_reg;
  logic [PtrW-1:0]      rd_ptr_reg;
  logic [CntW-1:0]      count_reg;

  // Pointer advance with explicit wrap so Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage has no reset so it stays a plain RAM array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CntW'(push) - CntW'(pop);
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/knn_sp_stream_reader.sv
// Read-side streamer for the per-PE search-point buffer. Issues sequential
// reads over [cmd_base, cmd_base+cmd_count) (addresses wrap modulo the buffer
// size), tracks the fixed read latency with a ce0 shift register and lands the
// returning words in a credit-protected skid FIFO, presented as a valid/ready
// stream with out_last on the final word.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake (ready only in IDLE)
//   cmd_base, cmd_count             : first address, number of words (0..AddressRange)
//   address0, ce0, we0, d0, q0      : buffer port (write side tied off)
//   out_valid/out_ready, out_data   : search-point word stream
//   out_last                        : final word of the command
//   busy, done                      : FSM not idle, one-cycle completion pulse
//   stall_cycles                    : consumer back-pressure counter, only when
//                                     KNN_SP_READER_PERF_EN is defined
module knn_sp_stream_reader
  import knn_pkg::*;
#(
  parameter int DataWidth    = SP_DATA_W,
  parameter int AddressWidth = SP_ADDR_W,
  parameter int AddressRange = 2048,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressWidth-1:0] cmd_base,
  input  logic [AddressWidth:0]   cmd_count,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  input  logic [DataWidth-1:0]    q0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
`ifdef KNN_SP_READER_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int CntW = AddressWidth + 1;
  localparam int IfW  = $clog2(READ_LATENCY + 1);
  localparam int FcW  = $clog2(FIFO_DEPTH + 1);

  reader_state_t state_reg, state_next;
  logic [AddressWidth-1:0] base_reg, base_next;
  logic [CntW-1:0]         count_reg, count_next;
  logic [CntW-1:0]         issued_reg, issued_next;
  logic [CntW-1:0]         sent_reg, sent_next;
  logic                    done_reg, done_next;
  logic [IfW-1:0]          inflight_reg, inflight_next;
  logic [READ_LATENCY-1:0] lat_sr_reg, lat_sr_next;

  logic            issue;
  logic            credit;
  logic            tail;
  logic            pop;
  logic            last_beat;
  logic            fifo_empty;
  logic [FcW-1:0]  fifo_count;
  logic [CntW-1:0] cmd_count_clamped;

  // Oversized counts are clamped to the buffer depth.
  assign cmd_count_clamped = (cmd_count > CntW'(AddressRange)) ? CntW'(AddressRange) : cmd_count;

  // Every word already requested (in flight or parked in the FIFO) owns a FIFO
  // slot, so the FIFO can never overflow regardless of out_ready.
  assign credit = (32'(inflight_reg) + 32'(fifo_count)) < 32'(FIFO_DEPTH);

  // ce0 delay line: its tail marks the cycle q0 carries the requested word.
  assign lat_sr_next[0] = issue;
  generate
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_lat
      assign lat_sr_next[gi] = lat_sr_reg[gi-1];
    end
  endgenerate
  assign tail = lat_sr_reg[READ_LATENCY-1];

  assign pop       = out_valid && out_ready;
  assign last_beat = (sent_reg == count_reg - 1'b1);

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    count_next    = count_reg;
    issued_next   = issued_reg;
    sent_next     = sent_reg;
    done_next     = 1'b0;
    issue         = 1'b0;
    inflight_next = inflight_reg + IfW'(issue) - IfW'(tail);

    if (pop) begin
      sent_next = sent_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          base_next   = cmd_base;
          count_next  = cmd_count_clamped;
          issued_next = '0;
          sent_next   = '0;
          if (cmd_count_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          issue       = 1'b1;
          issued_next = issued_reg + 1'b1;
          if (issued_next == count_reg) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Words leave in order, so accepting the last one implies nothing
        // remains in flight or in the FIFO.
        if (pop && last_beat) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    inflight_next = inflight_reg + IfW'(issue) - IfW'(tail);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      count_reg    <= '0;
      issued_reg   <= '0;
      sent_reg     <= '0;
      done_reg     <= 1'b0;
      inflight_reg <= '0;
      lat_sr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      count_reg    <= count_next;
      issued_reg   <= issued_next;
      sent_reg     <= sent_next;
      done_reg     <= done_next;
      inflight_reg <= inflight_next;
      lat_sr_reg   <= lat_sr_next;
    end
  end

  knn_sp_skid_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tail),
    .push_data (q0),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Truncation to AddressWidth gives the modulo-depth wrap.
  assign address0  = base_reg + issued_reg[AddressWidth-1:0];
  assign ce0       = issue;
  assign we0       = 1'b0;
  assign d0        = '0;
  assign out_valid = !fifo_empty;
  assign out_last  = out_valid && last_beat;
  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

`ifdef KNN_SP_READER_PERF_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset || (state_reg == IDLE && cmd_valid)) begin
      stall_cycles_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule
